qarma_tweakey_sched: RTL and testbench
======================================

Name: qarma_tweakey_sched

Overview:
- Iterative forward tweak-schedule unit for the QARMA-128 datapath, m = 8-bit cells.
- Sits directly upstream of the round's AddRoundTweakey → SubCells stage. Per round it produces rtk_i = T_i ^ k0 ^ c_i, which the datapath XORs into state before SubCells.
- Loads one (tweak, k0) pair through a valid/ready handshake, then streams R round tweakeys with backpressure.

Parameters:
- n, 128, state/tweak width; cell width m = n>>4.
- R, 11, number of forward round tweakeys emitted per load (1..16).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  tweak/key offered
- in_ready  output  1  unit can accept a load
- in_tweak  input  n  initial tweak T_0
- in_key  input  n  round key k0
- out_valid  output  1  rtk_out holds a valid round tweakey
- out_ready  input  1  consumer accepts rtk_out
- rtk_out  output  n  T_i ^ k0 ^ c_i
- out_last  output  1  high with the round R-1 beat

Behaviour:
- Clocking/reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Cell layout: cell j = bits [j*m +: m], identical to the SubCells cell order.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. A load happens when in_valid && in_ready. It registers T←in_tweak, K←in_key, round←0 and moves to RUN.
  - RUN: out_valid=1, in_ready=0. rtk_out = T ^ K ^ RC[round], combinational from registers. out_last = (round == R-1).
    - On out_valid && out_ready with round < R-1: T←omega(h(T)), round←round+1.
    - On a handshake with round == R-1: go to IDLE.
- No back-to-back load overlaps: in_ready stays low through the whole RUN state. The first load accepted after the last beat is one cycle later (IDLE cycle).
- Latency: first rtk_out is valid the cycle after the load handshake. Without backpressure, R beats are emitted on consecutive cycles.
- Backpressure: while out_ready=0, T, round and rtk_out are held stable. out_valid never drops once asserted until the handshake.
- h permutation: out cell i = in cell h[i], with h = {6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11}.
- omega LFSR: applied after h to cells {0,1,3,4,8,11,13}. For byte b7..b0 (b7 MSB), the result is {b0^b2, b7, b6, b5, b4, b3, b2, b1}. All other cells pass unchanged.
- Round constants: RC[0] = 0; RC[1] = 0x243F6A8885A308D313198A2E03707344; further entries are the QARMA-128 constants from the package.
- Reset values: in_ready=1 (IDLE). out_valid=0, out_last=0, rtk_out=0 (registers T, K cleared), round=0.
- Reset mid-RUN: the in-flight sequence is abandoned with no further beats. The unit is back in IDLE the next cycle.
- in_valid while in RUN is ignored (in_ready=0). The producer must hold its data.
- R=1: a single beat with out_last=1.

Optional Feature:
- Macro: QARMA_TWEAKEY_ZEROIZE_EN.
- Defined: on the final handshake (round R-1), registers T and K are cleared to 0 alongside the return to IDLE, so no key material remains after use. rtk_out reads 0 in IDLE.
- Undefined: T and K retain their last values in IDLE. rtk_out in IDLE is don't-care but must equal the registers' XOR with RC[0].

Decomposition:
- Package qarma128_pkg holds:
  - cell-width constant M=8
  - typedef cell_t (logic [7:0]) and state_t (logic [127:0])
  - the h table as a localparam array
  - the omega cell mask (16'b0010_1001_0001_1011, bit j = cell j)
  - the RC[0..15] constant array
- One sub-module is natural: qarma_tweak_update, a combinational h followed by omega on one n-bit word. It is reusable by the backward schedule later.

Test Plan:
- tweak=0, key=0, R=11, out_ready=1 → beat0 rtk=0; beat1 rtk=0x243F6A8885A308D313198A2E03707344; 11 consecutive beats; out_last only on beat 10; in_ready re-asserts the following cycle.
- tweak = 0x01 in cell 2 (bits[23:16]), key=0 → beat1 rtk = RC[1] ^ (0x01 in cell 6) (h moves cell 2→6, no omega).
- tweak = 0x01 in cell 0, key=0 → beat1 rtk = RC[1] ^ (0x80 in cell 4) (h moves 0→4, omega(0x01)=0x80).
- Hold out_ready=0 for 5 cycles at beat 3 → rtk_out and out_last stable, out_valid high, beat 4 only after release; in_valid pulses during RUN not accepted.
- Assert rst during beat 5 → next cycle out_valid=0, in_ready=1, rtk_out=0. A new load then restarts at beat0.
- With QARMA_TWEAKEY_ZEROIZE_EN: after out_last handshake with key=all-ones, IDLE rtk_out=0. Without the macro: IDLE rtk_out ≠ 0.

Source files
------------

// File: rtl/qarma128_pkg.sv
// Shared QARMA-128 definitions for the tweak schedule and datapath.
// It defines the cell and state types, the h cell permutation, the omega LFSR
// cell mask and the forward round constants RC[0..15].
// Cell j of a state word occupies bits [j*M +: M].
package qarma128_pkg;

    localparam int unsigned M        = 8;
    localparam int unsigned NumCells = 16;

    typedef logic [M-1:0] cell_t;
    typedef logic [127:0] state_t;

    // Output cell i of h takes input cell HTable[i].
    localparam int unsigned HTable [NumCells] = '{
        6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11
    };

    // Bit j set means cell j passes through the omega LFSR after h.
    localparam logic [NumCells-1:0] OmegaMask = 16'b0010_1001_0001_1011;

    // Forward round constants. RC[1] onward are consecutive 128-bit chunks of
    // the hex expansion of pi.
    localparam state_t RoundConst [16] = '{
        128'h00000000000000000000000000000000,
        128'h243F6A8885A308D313198A2E03707344,
        128'hA4093822299F31D0082EFA98EC4E6C89,
        128'h452821E638D01377BE5466CF34E90C6C,
        128'hC0AC29B7C97C50DD3F84D5B5B5470917,
        128'h9216D5D98979FB1BD1310BA698DFB5AC,
        128'h2FFD72DBD01ADFB7B8E1AFED6A267E96,
        128'hBA7C9045F12C7F9924A19947B3916CF7,
        128'h0801F2E2858EFC16636920D871574E69,
        128'hA458FEA3F4933D7E0D95748F728EB658,
        128'h718BCD5882154AEE7B54A41DC25A59B5,
        128'h9C30D5392AF26013C5D1B023286085F0,
        128'hCA417918B8DB38EF8E79DCB0603A180E,
        128'h6C9E0E8BB01E8A3ED71577C1BD314B27,
        128'h78AF2FDA55605C60E65525F3AA55AB94,
        128'h5748986263E8144055CA396A2AAB10B6
    };

    // One forward step of the cell LFSR: {b0^b2, b7..b1}.
    function automatic cell_t omega_cell(input cell_t b);
        return {b[0] ^ b[2], b[7:1]};
    endfunction

endpackage

// File: rtl/qarma_tweak_update.sv
// Forward tweak update for QARMA-128: applies the h cell permutation, then
// omega to the cells selected by OmegaMask. It is purely combinational.
// Ports:
//   tweak   - current tweak T_i
//   updated - omega(h(T_i)) = T_{i+1}
module qarma_tweak_update
    import qarma128_pkg::*;
(
    input  state_t tweak,
    output state_t updated
);

    state_t permuted;

    for (genvar i = 0; i < NumCells; i++) begin : g_cell
        assign permuted[i*M +: M] = tweak[HTable[i]*M +: M];

        if (OmegaMask[i]) begin : g_lfsr
            assign updated[i*M +: M] = omega_cell(permuted[i*M +: M]);
        end else begin : g_pass
            assign updated[i*M +: M] = permuted[i*M +: M];
        end
    end

endmodule

// File: rtl/qarma_tweakey_sched.sv
// Iterative forward tweakey schedule for QARMA-128.
// The unit accepts one (tweak, k0) pair, then streams R round tweakeys
// rtk_i = T_i ^ k0 ^ RC[i] under valid/ready backpressure.
// Optional build macro QARMA_TWEAKEY_ZEROIZE_EN clears T and K on the final
// handshake, so that no key material is left behind in IDLE.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - load handshake for in_tweak / in_key
//   in_tweak, in_key    - initial tweak T_0 and round key k0
//   out_valid, out_ready- output handshake for rtk_out
//   rtk_out             - current round tweakey
//   out_last            - marks the round R-1 beat
module qarma_tweakey_sched
    import qarma128_pkg::*;
#(
    parameter int unsigned N = 128,
    parameter int unsigned R = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_tweak,
    input  logic [N-1:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] rtk_out,
    output logic         out_last
);

    localparam logic [3:0] LastRound = 4'(R - 1);

    typedef enum logic [0:0] {StIdle, StRun} fsm_t;

    fsm_t       state_q;
    state_t     tweak_q;
    state_t     key_q;
    logic [3:0] round_q;
    state_t     tweak_next;
    logic       at_last;

    qarma_tweak_update u_update (
        .tweak   (tweak_q),
        .updated (tweak_next)
    );

    assign at_last = (round_q == LastRound);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tweak_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        tweak_q <= in_tweak;
                        key_q   <= in_key;
                        round_q <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (out_ready) begin
                        if (at_last) begin
                            // Round returns to 0 so IDLE output is T ^ K ^ RC[0].
                            round_q <= '0;
                            state_q <= StIdle;
`ifdef QARMA_TWEAKEY_ZEROIZE_EN
                            tweak_q <= '0;
                            key_q   <= '0;
`endif
                        end else begin
                            tweak_q <= tweak_next;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StRun);
    // The state gate stops out_last from showing in IDLE when R == 1.
    assign out_last  = out_valid && at_last;
    assign rtk_out   = tweak_q ^ key_q ^ RoundConst[round_q];

endmodule

// File: tb/tb_qarma_tweakey_sched.sv
// Directed self-checking bench for qarma_tweakey_sched (R = 11).
module tb_qarma_tweakey_sched;

    localparam int unsigned N = 128;
    localparam int unsigned R = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_tweak;
    logic [N-1:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] rtk_out;
    logic         out_last;

    int vectors     = 0;
    int miscompares = 0;

    // Hand-copied forward constants RC[0..4] (hex digits of pi).
    logic [127:0] rc_exp [5];
    logic [127:0] key_a;

    qarma_tweakey_sched #(
        .N (N),
        .R (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tweak  (in_tweak),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rtk_out   (rtk_out),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] t, input logic [N-1:0] k);
        for (int n = 0; n < 50 && !in_ready; n++) tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ready: in_ready=%b want 1", in_ready);
        end
        in_tweak = t;
        in_key   = k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            if (out_valid && out_last) done = 1'b1;
            tick();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_last: last beat seen=%b want 1", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tweak = '0; in_key = '0;
        tick();
        tick();
        rst = 1'b0;
        vectors += 4;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        if (out_last !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last);
        end
        if (rtk_out !== '0) begin
            miscompares++; $display("FAIL reset_rtk: got %h want 0", rtk_out);
        end
    endtask

    task automatic test_zero_stream();
        out_ready = 1'b1;
        load('0, '0);
        for (int i = 0; i < R; i++) begin
            vectors += 3;
            if (out_valid !== 1'b1) begin
                miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid);
            end
            if (out_last !== (i == R - 1)) begin
                miscompares++;
                $display("FAIL stream_last[%0d]: got %b want %b", i, out_last, (i == R - 1));
            end
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            if (i < 5) begin
                vectors++;
                if (rtk_out !== rc_exp[i]) begin
                    miscompares++;
                    $display("FAIL stream_rtk[%0d]: got %h want %h", i, rtk_out, rc_exp[i]);
                end
            end
            tick();
        end
        vectors += 2;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL stream_reready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stream_idle_valid: got %b want 0", out_valid);
        end
    endtask

    // Cell 2 moves to cell 6 under h; cell 6 is outside the omega mask.
    task automatic test_h_perm();
        logic [127:0] t;
        logic [127:0] exp1;
        t    = 128'h01 << 16;
        exp1 = rc_exp[1] ^ (128'h01 << 48);
        out_ready = 1'b1;
        load(t, '0);
        vectors++;
        if (rtk_out !== t) begin
            miscompares++; $display("FAIL hperm_beat0: got %h want %h", rtk_out, t);
        end
        tick();
        vectors++;
        if (rtk_out !== exp1) begin
            miscompares++; $display("FAIL hperm_beat1: got %h want %h", rtk_out, exp1);
        end
        drain();
    endtask

    // Cell 0 moves to cell 4 under h, then omega(0x01) = 0x80.
    task automatic test_omega();
        logic [127:0] exp1;
        exp1 = rc_exp[1] ^ (128'h80 << 32);
        out_ready = 1'b1;
        load(128'h01, '0);
        tick();
        vectors++;
        if (rtk_out !== exp1) begin
            miscompares++; $display("FAIL omega_beat1: got %h want %h", rtk_out, exp1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        load('0, key_a);
        tick(); tick(); tick();
        vectors++;
        if (rtk_out !== (key_a ^ rc_exp[3])) begin
            miscompares++;
            $display("FAIL bp_beat3: got %h want %h", rtk_out, key_a ^ rc_exp[3]);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            in_tweak = '1;
            in_key   = '0;
            tick();
            vectors += 4;
            if (rtk_out !== (key_a ^ rc_exp[3])) begin
                miscompares++;
                $display("FAIL bp_hold_rtk[%0d]: got %h want %h", c, rtk_out, key_a ^ rc_exp[3]);
            end
            if (out_valid !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid);
            end
            if (out_last !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold_last[%0d]: got %b want 0", c, out_last);
            end
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", c, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (rtk_out !== (key_a ^ rc_exp[4])) begin
            miscompares++;
            $display("FAIL bp_beat4: got %h want %h", rtk_out, key_a ^ rc_exp[4]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        load('0, key_a);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors += 3;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        if (rtk_out !== '0) begin
            miscompares++; $display("FAIL midrst_rtk: got %h want 0", rtk_out);
        end
        load('0, '0);
        vectors++;
        if (rtk_out !== rc_exp[0]) begin
            miscompares++; $display("FAIL midrst_beat0: got %h want %h", rtk_out, rc_exp[0]);
        end
        tick();
        vectors++;
        if (rtk_out !== rc_exp[1]) begin
            miscompares++; $display("FAIL midrst_beat1: got %h want %h", rtk_out, rc_exp[1]);
        end
        drain();
    endtask

    // Tweak 0 stays 0 through every update, so IDLE shows K (or 0 if zeroized).
    task automatic test_idle_residue();
        logic [127:0] exp_idle;
`ifdef QARMA_TWEAKEY_ZEROIZE_EN
        exp_idle = '0;
`else
        exp_idle = '1;
`endif
        out_ready = 1'b1;
        load('0, '1);
        drain();
        vectors += 2;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL residue_in_ready: got %b want 1", in_ready);
        end
        if (rtk_out !== exp_idle) begin
            miscompares++; $display("FAIL residue_rtk: got %h want %h", rtk_out, exp_idle);
        end
    endtask

    initial begin
        rc_exp[0] = 128'h00000000000000000000000000000000;
        rc_exp[1] = 128'h243F6A8885A308D313198A2E03707344;
        rc_exp[2] = 128'hA4093822299F31D0082EFA98EC4E6C89;
        rc_exp[3] = 128'h452821E638D01377BE5466CF34E90C6C;
        rc_exp[4] = 128'hC0AC29B7C97C50DD3F84D5B5B5470917;
        key_a     = 128'h0123456789ABCDEFFEDCBA9876543210;

        test_reset();
        test_zero_stream();
        test_h_perm();
        test_omega();
        test_backpressure();
        test_reset_mid();
        test_idle_residue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
